// File: rtl/pipe_wb_reg.sv
// MEM->WB pipeline register: two-entry skid buffer (head + skid) with registered outputs.
// Define WB_FWD_EN to add a combinational forwarding lookup port (fwd_addr/fwd_hit/fwd_data).
module pipe_wb_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic          up_we,
  input  logic [AW-1:0] up_w_addr,
  input  logic [DW-1:0] up_w_data,
  input  logic          dn_ready,
  output logic          dn_valid,
  output logic          wb_we,
  output logic [AW-1:0] wb_w_addr,
  output logic [DW-1:0] wb_w_data,
`ifdef WB_FWD_EN
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
`endif
  output logic [1:0]    occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          up_ready_q, up_ready_d;
  logic          dn_valid_q, dn_valid_d;
  logic          head_we_q, head_we_d;
  logic [AW-1:0] head_addr_q, head_addr_d;
  logic [DW-1:0] head_data_q, head_data_d;
  logic          skid_we_q, skid_we_d;
  logic [AW-1:0] skid_addr_q, skid_addr_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  logic          push;
  logic          pop;
  logic          cap_we;

  assign push   = up_valid & up_ready_q & rdy_in & ~flush_in;
  assign pop    = dn_valid_q & dn_ready & rdy_in & ~flush_in;
  // Writes to x0 are never presented downstream.
  assign cap_we = up_we & (up_w_addr != '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= EMPTY;
      up_ready_q  <= 1'b1;
      dn_valid_q  <= 1'b0;
      head_we_q   <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_we_q   <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      up_ready_q  <= up_ready_d;
      dn_valid_q  <= dn_valid_d;
      head_we_q   <= head_we_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_we_q   <= skid_we_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next state and entry movement; empty slots are kept zeroed so outputs read 0.
  always_comb begin
    state_d     = state_q;
    head_we_d   = head_we_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_we_d   = skid_we_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;

    if (rdy_in && flush_in) begin
      state_d     = EMPTY;
      head_we_d   = 1'b0;
      head_addr_d = '0;
      head_data_d = '0;
      skid_we_d   = 1'b0;
      skid_addr_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            head_we_d   = cap_we;
            head_addr_d = up_w_addr;
            head_data_d = up_w_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_we_d   = cap_we;
            head_addr_d = up_w_addr;
            head_data_d = up_w_data;
          end else if (push) begin
            state_d     = FULL;
            skid_we_d   = cap_we;
            skid_addr_d = up_w_addr;
            skid_data_d = up_w_data;
          end else if (pop) begin
            state_d     = EMPTY;
            head_we_d   = 1'b0;
            head_addr_d = '0;
            head_data_d = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            head_we_d   = skid_we_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
            skid_we_d   = 1'b0;
            skid_addr_d = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    up_ready_d = (state_d != FULL);
    dn_valid_d = (state_d != EMPTY);
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign wb_we     = head_we_q & dn_valid_q;
  assign wb_w_addr = head_addr_q;
  assign wb_w_data = head_data_q;
  assign occ       = 2'(state_q);

`ifdef WB_FWD_EN
  logic skid_vld;
  assign skid_vld = (state_q == FULL);

  // Skid is younger than head, so a skid match overrides a head match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (dn_valid_q && head_we_q && (head_addr_q == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = head_data_q;
    end
    if (skid_vld && skid_we_q && (skid_addr_q == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_data_q;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Scoreboard bench for pipe_wb_reg: a queue models buffered entries and predicts the output vector.
module tb_pipe_wb_reg;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned VW = 5 + AW + DW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b1;
  logic          flush_in = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic          up_we = 1'b0;
  logic [AW-1:0] up_w_addr = '0;
  logic [DW-1:0] up_w_data = '0;
  logic          dn_ready = 1'b0;
  logic          dn_valid;
  logic          wb_we;
  logic [AW-1:0] wb_w_addr;
  logic [DW-1:0] wb_w_data;
  logic [1:0]    occ;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  pipe_wb_reg #(.DW(DW), .AW(AW)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_we     (up_we),
    .up_w_addr (up_w_addr),
    .up_w_data (up_w_data),
    .dn_ready  (dn_ready),
    .dn_valid  (dn_valid),
    .wb_we     (wb_we),
    .wb_w_addr (wb_w_addr),
    .wb_w_data (wb_w_data),
`ifdef WB_FWD_EN
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .occ       (occ)
  );

  always #5 clk_in = ~clk_in;

  ent_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [VW-1:0] obs;
  logic [VW-1:0] rst_vec;

  function automatic logic [VW-1:0] exp_vec();
    if (sb.size() == 0) return {1'b0, 1'b1, 2'd0, 1'b0, {AW{1'b0}}, {DW{1'b0}}};
    return {1'b1, 1'(sb.size() < 2), 2'(sb.size()), sb[0].we, sb[0].addr, sb[0].data};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {dn_valid, up_ready, occ, wb_we, wb_w_addr, wb_w_data};
  endfunction

  // One clock of stimulus; the model is updated with the same push/pop rules at the edge.
  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic dr, input logic rdy,
                       input logic fl);
    logic push;
    logic pop;
    ent_t e;
    up_valid  = v;
    up_we     = we;
    up_w_addr = a;
    up_w_data = d;
    dn_ready  = dr;
    rdy_in    = rdy;
    flush_in  = fl;
    push   = v && (sb.size() < 2) && rdy && !fl;
    pop    = (sb.size() > 0) && dr && rdy && !fl;
    e.we   = we && (a != '0);
    e.addr = a;
    e.data = d;
    @(posedge clk_in);
    if (rdy && fl) sb.delete();
    else begin
      if (pop) sb.delete(0);
      if (push) sb.push_back(e);
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    obs = obs_vec();
    total++;
    if (obs !== rst_vec) begin
      bad++;
      $display("FAIL reset_during: got %h want %h", obs, rst_vec);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    obs = obs_vec();
    total++;
    if (obs !== rst_vec) begin
      bad++;
      $display("FAIL reset_after: got %h want %h", obs, rst_vec);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, AW'(3), 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    obs = obs_vec();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL single_vec: got %h want %h", obs, exp_vec());
    end
    total++;
    if ({wb_we, wb_w_addr, wb_w_data, occ} !== {1'b1, 5'd3, 32'hDEADBEEF, 2'd1}) begin
      bad++;
      $display("FAIL single_fields: got %h want %h", {wb_we, wb_w_addr, wb_w_data, occ},
               {1'b1, 5'd3, 32'hDEADBEEF, 2'd1});
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    obs = obs_vec();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL single_drain: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_skid();
    for (int i = 4; i <= 6; i++) begin
      drive(1'b1, 1'b1, AW'(i), DW'(i * 17), 1'b0, 1'b1, 1'b0);
      obs = obs_vec();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL skid_fill%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if ({occ, up_ready, wb_w_addr} !== {2'd2, 1'b0, 5'd4}) begin
      bad++;
      $display("FAIL skid_full: got %h want %h", {occ, up_ready, wb_w_addr}, {2'd2, 1'b0, 5'd4});
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({wb_w_addr, wb_w_data, occ} !== {5'd5, 32'd85, 2'd1}) begin
      bad++;
      $display("FAIL skid_order: got %h want %h", {wb_w_addr, wb_w_data, occ}, {5'd5, 32'd85, 2'd1});
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      obs = obs_vec();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL skid_drain%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, '0, 32'h55, 1'b0, 1'b1, 1'b0);
    total++;
    if ({dn_valid, wb_we, wb_w_data} !== {1'b1, 1'b0, 32'h55}) begin
      bad++;
      $display("FAIL x0_we: got %h want %h", {dn_valid, wb_we, wb_w_data}, {1'b1, 1'b0, 32'h55});
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    obs = obs_vec();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL x0_drain: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, AW'(1), 32'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, AW'(2), 32'h22, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, AW'(9), 32'h99, 1'b1, 1'b1, 1'b1);
    total++;
    if ({occ, dn_valid, up_ready} !== {2'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL flush_state: got %h want %h", {occ, dn_valid, up_ready}, {2'd0, 1'b0, 1'b1});
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    obs = obs_vec();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL flush_dropped: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, AW'(8), 32'h88, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, AW'(10 + i), DW'(i), 1'b1, 1'b0, 1'(i == 1));
      obs = obs_vec();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL stall_vec%0d: got %h want %h", i, obs, exp_vec());
      end
      total++;
      if ({occ, wb_we, wb_w_addr, wb_w_data} !== {2'd1, 1'b1, 5'd8, 32'h88}) begin
        bad++;
        $display("FAIL stall_hold%0d: got %h want %h", i, {occ, wb_we, wb_w_addr, wb_w_data},
                 {2'd1, 1'b1, 5'd8, 32'h88});
      end
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, AW'(i + 1), DW'(32'hA000 + i), 1'b1, 1'b1, 1'b0);
      obs = obs_vec();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL b2b%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
            DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 15) == 0));
      obs = obs_vec();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rand%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, AW'(12), 32'hC0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, AW'(13), 32'hC1, 1'b0, 1'b1, 1'b0);
    up_valid = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    sb.delete();
    obs = obs_vec();
    total++;
    if (obs !== rst_vec) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs, rst_vec);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    obs = obs_vec();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_mid_after: got %h want %h", obs, exp_vec());
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    drive(1'b1, 1'b1, AW'(7), 32'h1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, AW'(7), 32'h2, 1'b0, 1'b1, 1'b0);
    fwd_addr = AW'(7);
    #1;
    total++;
    if ({fwd_hit, fwd_data} !== {1'b1, 32'h2}) begin
      bad++;
      $display("FAIL fwd_young: got %h want %h", {fwd_hit, fwd_data}, {1'b1, 32'h2});
    end
    fwd_addr = AW'(3);
    #1;
    total++;
    if ({fwd_hit, fwd_data} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL fwd_miss: got %h want %h", {fwd_hit, fwd_data}, {1'b0, 32'h0});
    end
    @(negedge clk_in);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    rst_vec = {1'b0, 1'b1, 2'd0, 1'b0, {AW{1'b0}}, {DW{1'b0}}};
    test_reset();
    test_single();
    test_skid();
    test_x0();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_wb_reg.md
PIPE_WB_REG -- requirements
Module: pipe_wb_reg

Interface
REQ-001 SHALL have parameter DW, default 32, meaning write-data width.
REQ-002 SHALL have parameter AW, default 5, meaning destination register index width.
REQ-003 SHALL have port clk_in, input, 1, meaning the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, meaning the reset: asynchronous, active-high.
REQ-005 SHALL have port rdy_in, input, 1, meaning global enable; low freezes all state.
REQ-006 SHALL have port flush_in, input, 1, meaning discard all buffered entries.
REQ-007 SHALL have port up_valid, input, 1, meaning the MEM stage offers an entry.
REQ-008 SHALL have port up_ready, output, 1, meaning the stage can accept an entry.
REQ-009 SHALL have ports up_we (input, 1), up_w_addr (input, AW) and up_w_data (input, DW), meaning the offered write-enable, address and data.
REQ-010 SHALL have port dn_ready, input, 1, meaning the WB side consumes the head entry this cycle.
REQ-011 SHALL have port dn_valid, output, 1, meaning the head entry is valid.
REQ-012 SHALL have ports wb_we (output, 1), wb_w_addr (output, AW) and wb_w_data (output, DW), meaning the head entry fields, all registered.
REQ-013 SHALL have port occ, output, 2, meaning the entry count, 0 to 2.

Function
REQ-014 SHALL hold two entries: head (drives the wb_* outputs) and skid.
REQ-015 SHALL have states EMPTY, ONE and FULL, with occ equal to 0, 1 and 2 respectively.
REQ-016 SHALL define push = up_valid & up_ready & rdy_in & !flush_in.
REQ-017 SHALL define pop = dn_valid & dn_ready & rdy_in & !flush_in.
REQ-018 SHALL drive up_ready = (state != FULL) from registered state only, with no combinational path from dn_ready.
REQ-019 SHALL make these transitions: EMPTY + push -> ONE; ONE + push without pop -> FULL; ONE + pop without push -> EMPTY; ONE + push + pop -> ONE, loading head from up_* in the same cycle; FULL + pop -> ONE, moving skid to head.
REQ-020 SHALL have a push-to-wb_* latency of exactly 1 cycle when EMPTY, or when ONE with a simultaneous pop.
REQ-021 SHALL force the captured we to 0 when up_w_addr == 0, so that no write to x0 is ever presented.
REQ-022 SHALL drive wb_we = head.we & dn_valid; when dn_valid = 0, wb_w_addr and wb_w_data SHALL be 0.
REQ-023 SHALL give flush_in = 1 priority over push and pop: at the next edge the state becomes EMPTY and both entries are zeroed.
REQ-024 SHALL leave all state unchanged while rdy_in = 0, even when up_valid, dn_ready or flush_in are asserted.
REQ-025 SHALL preserve entry order: an entry accepted earlier always reaches head earlier.

Reset
REQ-026 SHALL, while rst_in = 1, set the state to EMPTY and set occ = 0, dn_valid = 0, wb_we = 0, wb_w_addr = 0 and wb_w_data = 0.
REQ-027 SHALL set up_ready = 1 during and after reset.
REQ-028 SHALL discard, on a reset asserted mid-operation, any entry in flight; entries SHALL NOT be retained across reset.

Configuration
REQ-029 SHALL, with macro WB_FWD_EN defined, add input fwd_addr (AW) and outputs fwd_hit (1) and fwd_data (DW).
REQ-030 SHALL compute fwd_hit combinationally when WB_FWD_EN is defined: true if any valid entry with we = 1 has a matching address.
REQ-031 SHALL, when WB_FWD_EN is defined, take fwd_data from the youngest matching entry (skid before head), and drive fwd_data = 0 when there is no hit.
REQ-032 SHALL NOT have the fwd_* ports or any forwarding logic when WB_FWD_EN is undefined.

Verification
REQ-033 SHALL cover this scenario: after reset, push we=1, addr=3, data=0xDEADBEEF with dn_ready=1 -> next cycle wb_we=1, wb_w_addr=3, wb_w_data=0xDEADBEEF, occ=1.
REQ-034 SHALL cover this scenario: hold dn_ready=0 and push addr 4 then addr 5 -> occ=2 and up_ready=0; raise dn_ready -> addr 4 then addr 5 appear on wb_*, with no loss and no duplicate.
REQ-035 SHALL cover this scenario: push addr=0, we=1, data=0x55 -> dn_valid=1, wb_we=0.
REQ-036 SHALL cover this scenario: in FULL, assert flush_in together with up_valid -> next cycle occ=0, dn_valid=0, up_ready=1, and the offered entry is dropped.
REQ-037 SHALL cover this scenario: drop rdy_in to 0 for 3 cycles with traffic on up_valid and dn_ready -> wb_* and occ are unchanged throughout.
REQ-038 SHALL cover this scenario, with WB_FWD_EN defined: head holds addr 7 data 0x1 and skid holds addr 7 data 0x2, with fwd_addr=7 -> fwd_hit=1, fwd_data=0x2.
